ni_param: RTL and testbench

- Parametrised GPU-to-NoC network interface: one per GPU leaf, between the GPU port and its leaf router.
- Egress: translates the GPU destination ID in the top ID_W bits into a routing header (group/leaf address), buffers, sends to the router.
- Ingress: accepts router flits, filters on own address, restores GPU ID, buffers, delivers to the GPU.
- Successor to the fixed 16-bit/6-bit NI: full valid/ready on all four channels, arithmetic address map, correct pointer/count widths for any power-of-2 depth, saturating drop counter.

---
 rtl/ni_pkg.sv | 20 ++
 rtl/ni_sync_fifo.sv | 51 +++++
 rtl/ni_param.sv | 106 ++++++++++
 tb/tb_ni_param.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ni_pkg.sv
// ni_pkg: default address-map constants and GPU-ID/routing-address helpers
// shared by the network interface, the leaf router and the testbench.
package ni_pkg;

  localparam int NI_MAX_GPU     = 32;
  localparam int NI_ADDR_OFFSET = 3;

  function automatic int id_to_addr(input int id, input int offset);
    return id + offset;
  endfunction

  function automatic int addr_to_id(input int addr, input int offset);
    return addr - offset;
  endfunction

  function automatic bit id_valid(input int id, input int max_gpu);
    return (id >= 1) && (id <= max_gpu);
  endfunction

endpackage

// File: rtl/ni_sync_fifo.sv
// ni_sync_fifo: first-word-fall-through synchronous FIFO with occupancy count;
// a push while full is refused even if a pop happens in the same cycle.
module ni_sync_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic [W-1:0]  mem_q [DEPTH];
  logic          do_push, do_pop;

  // flags and head-of-queue read straight from registered state
  always_comb begin
    full_o  = cnt_q == (AW+1)'(DEPTH);
    empty_o = cnt_q == '0;
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    data_o  = mem_q[rd_q];
  end

  // pointers wrap naturally; simultaneous push and pop keep the count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(do_push);
      rd_q  <= rd_q + AW'(do_pop);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // storage is not reset; stale entries are never visible while empty
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/ni_param.sv
// ni_param: GPU-to-NoC network interface. Egress maps the GPU destination ID
// to a routing address, ingress filters on this NI's own address and restores
// the GPU ID; one FWFT FIFO per direction and a saturating drop counter.
// Optional NI_LOOPBACK_EN: self-addressed egress flits skip the router and go
// straight into the ingress FIFO, router pushes taking priority.
module ni_param
  import ni_pkg::*;
#(
  parameter int GPU_ID      = 1,
  parameter int DATA_W      = 16,
  parameter int ID_W        = 6,
  parameter int MAX_GPU     = NI_MAX_GPU,
  parameter int ADDR_OFFSET = NI_ADDR_OFFSET,
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] gpu_data_in,
  input  logic              gpu_valid_in,
  output logic              gpu_ready_out,
  output logic [DATA_W-1:0] gpu_data_out,
  output logic              gpu_valid_out,
  input  logic              gpu_ready_in,
  output logic [DATA_W-1:0] router_data_out,
  output logic              router_valid_out,
  input  logic              router_ready_in,
  input  logic [DATA_W-1:0] router_data_in,
  input  logic              router_valid_in,
  output logic              router_ready_out,
  output logic [CNT_W-1:0]  drop_count
);

  localparam int PW = DATA_W - ID_W;

  logic [ID_W-1:0]   e_id, r_addr;
  logic              e_ok, e_self, e_fire, e_push, e_drop, lb_push;
  logic              r_match, r_fire, r_push, r_drop;
  logic              eg_full, eg_empty, in_full, in_empty, in_push;
  logic [DATA_W-1:0] eg_din, eg_dout, in_din, in_dout;
  logic [CNT_W:0]    drop_sum;
  logic [CNT_W-1:0]  drop_q, drop_d;

  // handshakes, address translation, loopback steering and drop detection
  always_comb begin
    e_id     = gpu_data_in[DATA_W-1 -: ID_W];
    r_addr   = router_data_in[DATA_W-1 -: ID_W];
    e_ok     = id_valid(int'(e_id), MAX_GPU);
    r_match  = int'(r_addr) == id_to_addr(GPU_ID, ADDR_OFFSET);
    router_ready_out = !in_full;
    r_fire   = router_valid_in && router_ready_out;
    r_push   = r_fire && r_match;
    r_drop   = r_fire && !r_match;
`ifdef NI_LOOPBACK_EN
    e_self        = int'(e_id) == GPU_ID;
    gpu_ready_out = e_self ? (!in_full && !r_push) : !eg_full;
`else
    e_self        = 1'b0;
    gpu_ready_out = !eg_full;
`endif
    e_fire   = gpu_valid_in && gpu_ready_out;
    lb_push  = e_fire && e_self;
    e_push   = e_fire && e_ok && !e_self;
    e_drop   = e_fire && !e_ok;
    eg_din   = {ID_W'(id_to_addr(int'(e_id), ADDR_OFFSET)), gpu_data_in[PW-1:0]};
    in_push  = r_push || lb_push;
    in_din   = r_push ? {ID_W'(addr_to_id(int'(r_addr), ADDR_OFFSET)), router_data_in[PW-1:0]}
                      : gpu_data_in;
    router_valid_out = !eg_empty;
    gpu_valid_out    = !in_empty;
    router_data_out  = router_valid_out ? eg_dout : '0;
    gpu_data_out     = gpu_valid_out ? in_dout : '0;
    drop_sum = {1'b0, drop_q} + (CNT_W+1)'(e_drop) + (CNT_W+1)'(r_drop);
    drop_d   = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    drop_count = drop_q;
  end

  // drop counter accumulates both directions and sticks at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_q <= '0;
    else       drop_q <= drop_d;
  end

  ni_sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_egress (
    .clk     (clk),
    .reset   (reset),
    .push_i  (e_push),
    .data_i  (eg_din),
    .pop_i   (router_ready_in),
    .data_o  (eg_dout),
    .full_o  (eg_full),
    .empty_o (eg_empty)
  );

  ni_sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_ingress (
    .clk     (clk),
    .reset   (reset),
    .push_i  (in_push),
    .data_i  (in_din),
    .pop_i   (gpu_ready_in),
    .data_o  (in_dout),
    .full_o  (in_full),
    .empty_o (in_empty)
  );

endmodule

// File: tb/tb_ni_param.sv
// tb_ni_param: randomized and directed checks of ni_param against a queue-based
// model of both directions and the saturating drop counter.
module tb_ni_param;
  localparam int DW = 16, IW = 6, GID = 6, OFF = 3, MAXG = 32, DEP = 8, CW = 3;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0, reset = 1'b1;
  logic [DW-1:0] gpu_data_in = '0, router_data_in = '0;
  logic gpu_valid_in = 1'b0, gpu_ready_in = 1'b0, router_ready_in = 1'b0, router_valid_in = 1'b0;
  logic gpu_ready_out, gpu_valid_out, router_valid_out, router_ready_out;
  logic [DW-1:0] gpu_data_out, router_data_out;
  logic [CW-1:0] drop_count;

  int checks = 0, errors = 0, drops = 0;
  logic [DW-1:0] eg_q[$], in_q[$];
  bit e_fired, r_fired;

  always #5 clk = ~clk;

  ni_param #(.GPU_ID(GID), .DATA_W(DW), .ID_W(IW), .MAX_GPU(MAXG), .ADDR_OFFSET(OFF),
             .FIFO_DEPTH(DEP), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .gpu_data_in(gpu_data_in), .gpu_valid_in(gpu_valid_in), .gpu_ready_out(gpu_ready_out),
    .gpu_data_out(gpu_data_out), .gpu_valid_out(gpu_valid_out), .gpu_ready_in(gpu_ready_in),
    .router_data_out(router_data_out), .router_valid_out(router_valid_out), .router_ready_in(router_ready_in),
    .router_data_in(router_data_in), .router_valid_in(router_valid_in), .router_ready_out(router_ready_out),
    .drop_count(drop_count)
  );

  function automatic logic [DW-1:0] with_top(input int top, input logic [DW-1:0] d);
    return {top[IW-1:0], d[DW-IW-1:0]};
  endfunction

  function automatic bit exp_gpu_ready();
`ifdef NI_LOOPBACK_EN
    bit rp;
    rp = router_valid_in && in_q.size() < DEP && int'(router_data_in[DW-1 -: IW]) == GID + OFF;
    if (int'(gpu_data_in[DW-1 -: IW]) == GID) return in_q.size() < DEP && !rp;
`endif
    return eg_q.size() < DEP;
  endfunction

  // advance one clock, applying the current inputs to the model
  task automatic cycle();
    int id, addr, nd;
    bit rdy, r_push, lb, pop_e, pop_i;
    id = int'(gpu_data_in[DW-1 -: IW]);
    addr = int'(router_data_in[DW-1 -: IW]);
    nd = 0;
    lb = 1'b0;
    rdy = exp_gpu_ready();
    r_fired = router_valid_in && in_q.size() < DEP;
    r_push = r_fired && addr == GID + OFF;
`ifdef NI_LOOPBACK_EN
    lb = id == GID;
`endif
    e_fired = gpu_valid_in && rdy;
    pop_e = router_ready_in && eg_q.size() != 0;
    pop_i = gpu_ready_in && in_q.size() != 0;
    if (pop_e) void'(eg_q.pop_front());
    if (pop_i) void'(in_q.pop_front());
    if (e_fired) begin
      if (lb) in_q.push_back(gpu_data_in);
      else if (id >= 1 && id <= MAXG) eg_q.push_back(with_top(id + OFF, gpu_data_in));
      else nd++;
    end
    if (r_fired) begin
      if (r_push) in_q.push_back(with_top(addr - OFF, router_data_in));
      else nd++;
    end
    drops = (drops + nd > SAT) ? SAT : drops + nd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    gpu_valid_in = 1'b0;
    router_valid_in = 1'b0;
    e_fired = 1'b0;
    r_fired = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    checks += 7;
    if (router_valid_out !== 1'b0) begin errors++; $display("FAIL rst_router_valid got %b exp 0", router_valid_out); end
    if (gpu_valid_out !== 1'b0) begin errors++; $display("FAIL rst_gpu_valid got %b exp 0", gpu_valid_out); end
    if (gpu_ready_out !== 1'b1) begin errors++; $display("FAIL rst_gpu_ready got %b exp 1", gpu_ready_out); end
    if (router_ready_out !== 1'b1) begin errors++; $display("FAIL rst_router_ready got %b exp 1", router_ready_out); end
    if (drop_count !== '0) begin errors++; $display("FAIL rst_drop got %0d exp 0", drop_count); end
    if (router_data_out !== '0) begin errors++; $display("FAIL rst_router_data got %h exp 0", router_data_out); end
    if (gpu_data_out !== '0) begin errors++; $display("FAIL rst_gpu_data got %h exp 0", gpu_data_out); end
    reset = 1'b0;
    eg_q.delete();
    in_q.delete();
    drops = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_egress_basic();
    router_ready_in = 1'b1;
    gpu_valid_in = 1'b1;
    gpu_data_in = 16'h1C05;
    cycle();
    gpu_valid_in = 1'b0;
    checks += 4;
    if (router_valid_out !== 1'b1) begin errors++; $display("FAIL eg_basic_valid got %b exp 1", router_valid_out); end
    if (router_data_out !== 16'h2805) begin errors++; $display("FAIL eg_basic_data got %h exp 2805", router_data_out); end
    if (drop_count !== '0) begin errors++; $display("FAIL eg_basic_drop got %0d exp 0", drop_count); end
    cycle();
    if (router_valid_out !== 1'b0) begin errors++; $display("FAIL eg_basic_drained got %b exp 0", router_valid_out); end
  endtask

  task automatic test_ingress_filter();
    gpu_ready_in = 1'b0;
    router_valid_in = 1'b1;
    router_data_in = 16'h2455;
    #1;
    checks += 6;
    if (router_ready_out !== 1'b1) begin errors++; $display("FAIL in_rdy1 got %b exp 1", router_ready_out); end
    cycle();
    router_data_in = 16'h2855;
    if (router_ready_out !== 1'b1) begin errors++; $display("FAIL in_rdy2 got %b exp 1", router_ready_out); end
    cycle();
    router_valid_in = 1'b0;
    if (gpu_valid_out !== 1'b1) begin errors++; $display("FAIL in_valid got %b exp 1", gpu_valid_out); end
    if (gpu_data_out !== 16'h1855) begin errors++; $display("FAIL in_data got %h exp 1855", gpu_data_out); end
    if (drop_count !== 3'd1) begin errors++; $display("FAIL in_drop got %0d exp 1", drop_count); end
    gpu_ready_in = 1'b1;
    cycle();
    if (gpu_valid_out !== 1'b0) begin errors++; $display("FAIL in_single got %b exp 0", gpu_valid_out); end
  endtask

  task automatic test_fill();
    logic [DW-1:0] seq[$];
    int idx;
    router_ready_in = 1'b0;
    for (int i = 0; i < DEP; i++) begin
      gpu_valid_in = 1'b1;
      gpu_data_in = with_top($urandom_range(7, MAXG), DW'($urandom));
      seq.push_back(with_top(int'(gpu_data_in[DW-1 -: IW]) + OFF, gpu_data_in));
      cycle();
      checks++;
      if (gpu_ready_out !== (i < DEP - 1)) begin errors++; $display("FAIL fill_ready%0d got %b exp %b", i, gpu_ready_out, i < DEP - 1); end
    end
    gpu_data_in = with_top($urandom_range(7, MAXG), DW'($urandom));
    seq.push_back(with_top(int'(gpu_data_in[DW-1 -: IW]) + OFF, gpu_data_in));
    repeat (3) begin
      cycle();
      checks += 3;
      if (gpu_ready_out !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", gpu_ready_out); end
      if (router_valid_out !== 1'b1) begin errors++; $display("FAIL full_valid got %b exp 1", router_valid_out); end
      if (router_data_out !== seq[0]) begin errors++; $display("FAIL full_head got %h exp %h", router_data_out, seq[0]); end
    end
    router_ready_in = 1'b1;
    idx = 0;
    for (int k = 0; k < 14; k++) begin
      if (router_valid_out) begin
        checks++;
        if (idx >= seq.size() || router_data_out !== seq[idx]) begin
          errors++;
          $display("FAIL fill_order%0d got %h exp %h", idx, router_data_out, idx < seq.size() ? seq[idx] : 16'hxxxx);
        end
        idx++;
      end
      cycle();
      if (e_fired) gpu_valid_in = 1'b0;
    end
    checks++;
    if (idx != DEP + 1) begin errors++; $display("FAIL fill_count got %0d exp %0d", idx, DEP + 1); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] seq[$];
    int idx;
    router_ready_in = 1'b0;
    for (int i = 0; i < DEP / 2; i++) begin
      gpu_valid_in = 1'b1;
      gpu_data_in = with_top($urandom_range(7, MAXG), DW'($urandom));
      seq.push_back(with_top(int'(gpu_data_in[DW-1 -: IW]) + OFF, gpu_data_in));
      cycle();
    end
    router_ready_in = 1'b1;
    idx = 0;
    for (int i = 0; i < 20; i++) begin
      gpu_data_in = with_top($urandom_range(7, MAXG), DW'($urandom));
      seq.push_back(with_top(int'(gpu_data_in[DW-1 -: IW]) + OFF, gpu_data_in));
      #1;
      checks += 3;
      if (gpu_ready_out !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d got %b exp 1", i, gpu_ready_out); end
      if (router_valid_out !== 1'b1) begin errors++; $display("FAIL b2b_valid%0d got %b exp 1", i, router_valid_out); end
      if (router_data_out !== seq[idx]) begin errors++; $display("FAIL b2b_data%0d got %h exp %h", i, router_data_out, seq[idx]); end
      idx++;
      cycle();
    end
    gpu_valid_in = 1'b0;
    for (int i = 0; i < DEP / 2; i++) begin
      checks++;
      if (router_data_out !== seq[idx]) begin errors++; $display("FAIL b2b_tail%0d got %h exp %h", i, router_data_out, seq[idx]); end
      idx++;
      cycle();
    end
    checks++;
    if (router_valid_out !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b exp 0", router_valid_out); end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (!gpu_valid_in || e_fired) begin
        gpu_valid_in = 1'($urandom_range(0, 1));
        gpu_data_in = with_top($urandom_range(0, 40), DW'($urandom));
      end
      if (!router_valid_in || r_fired) begin
        router_valid_in = 1'($urandom_range(0, 1));
        router_data_in = with_top($urandom_range(0, 1) ? GID + OFF : $urandom_range(0, 63), DW'($urandom));
      end
      router_ready_in = $urandom_range(0, 3) != 0;
      gpu_ready_in = $urandom_range(0, 3) != 0;
      #1;
      checks += 2;
      if (gpu_ready_out !== exp_gpu_ready()) begin errors++; $display("FAIL rnd_gpu_ready%0d got %b exp %b", i, gpu_ready_out, exp_gpu_ready()); end
      if (router_ready_out !== (in_q.size() < DEP)) begin errors++; $display("FAIL rnd_router_ready%0d got %b exp %b", i, router_ready_out, in_q.size() < DEP); end
      cycle();
      checks += 5;
      if (router_valid_out !== (eg_q.size() != 0)) begin errors++; $display("FAIL rnd_router_valid%0d got %b exp %b", i, router_valid_out, eg_q.size() != 0); end
      if (eg_q.size() != 0 && router_data_out !== eg_q[0]) begin errors++; $display("FAIL rnd_router_data%0d got %h exp %h", i, router_data_out, eg_q[0]); end
      if (gpu_valid_out !== (in_q.size() != 0)) begin errors++; $display("FAIL rnd_gpu_valid%0d got %b exp %b", i, gpu_valid_out, in_q.size() != 0); end
      if (in_q.size() != 0 && gpu_data_out !== in_q[0]) begin errors++; $display("FAIL rnd_gpu_data%0d got %h exp %h", i, gpu_data_out, in_q[0]); end
      if (drop_count !== CW'(drops)) begin errors++; $display("FAIL rnd_drop%0d got %0d exp %0d", i, drop_count, drops); end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    router_ready_in = 1'b0;
    gpu_ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      gpu_valid_in = 1'b1;
      gpu_data_in = with_top($urandom_range(7, MAXG), DW'($urandom));
      router_valid_in = 1'b1;
      router_data_in = with_top(GID + OFF, DW'($urandom));
      cycle();
    end
    idle_inputs();
    checks += 2;
    if (router_valid_out !== 1'b1) begin errors++; $display("FAIL mid_pre_eg got %b exp 1", router_valid_out); end
    if (gpu_valid_out !== 1'b1) begin errors++; $display("FAIL mid_pre_in got %b exp 1", gpu_valid_out); end
    #2;
    reset = 1'b1;
    #1;
    checks += 2;
    if (router_valid_out !== 1'b0) begin errors++; $display("FAIL mid_async_eg got %b exp 0", router_valid_out); end
    if (gpu_valid_out !== 1'b0) begin errors++; $display("FAIL mid_async_in got %b exp 0", gpu_valid_out); end
    @(posedge clk);
    #2;
    reset = 1'b0;
    eg_q.delete();
    in_q.delete();
    drops = 0;
    @(posedge clk);
    #1;
    router_ready_in = 1'b1;
    gpu_ready_in = 1'b1;
    cycle();
    checks += 4;
    if (router_valid_out !== 1'b0) begin errors++; $display("FAIL mid_post_eg got %b exp 0", router_valid_out); end
    if (gpu_valid_out !== 1'b0) begin errors++; $display("FAIL mid_post_in got %b exp 0", gpu_valid_out); end
    if (drop_count !== '0) begin errors++; $display("FAIL mid_post_drop got %0d exp 0", drop_count); end
    if (gpu_ready_out !== 1'b1) begin errors++; $display("FAIL mid_post_ready got %b exp 1", gpu_ready_out); end
  endtask

  task automatic test_drops();
    router_ready_in = 1'b1;
    gpu_ready_in = 1'b1;
    gpu_valid_in = 1'b1;
    router_valid_in = 1'b1;
    gpu_data_in = with_top(0, 16'h0123);
    router_data_in = with_top(20, 16'h0456);
    cycle();
    checks += 3;
    if (drop_count !== 3'd2) begin errors++; $display("FAIL drop_pair1 got %0d exp 2", drop_count); end
    gpu_data_in = with_top(33, 16'h0789);
    router_data_in = with_top(2, 16'h0abc);
    cycle();
    if (drop_count !== 3'd4) begin errors++; $display("FAIL drop_pair2 got %0d exp 4", drop_count); end
    if (router_valid_out !== 1'b0 || gpu_valid_out !== 1'b0) begin errors++; $display("FAIL drop_stored got %b%b exp 00", router_valid_out, gpu_valid_out); end
    router_valid_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      gpu_data_in = with_top($urandom_range(MAXG + 1, 63), DW'($urandom));
      cycle();
      checks++;
      if (drop_count !== CW'(drops)) begin errors++; $display("FAIL drop_run%0d got %0d exp %0d", i, drop_count, drops); end
    end
    checks++;
    if (drop_count !== 3'd7) begin errors++; $display("FAIL drop_sat got %0d exp 7", drop_count); end
    idle_inputs();
  endtask

  task automatic test_self_addressed();
    logic [DW-1:0] sent;
    router_ready_in = 1'b0;
    gpu_ready_in = 1'b0;
    sent = with_top(GID, DW'($urandom));
    gpu_valid_in = 1'b1;
    gpu_data_in = sent;
    cycle();
    gpu_valid_in = 1'b0;
    checks += 3;
`ifdef NI_LOOPBACK_EN
    if (gpu_valid_out !== 1'b1) begin errors++; $display("FAIL lb_valid got %b exp 1", gpu_valid_out); end
    if (gpu_data_out !== sent) begin errors++; $display("FAIL lb_data got %h exp %h", gpu_data_out, sent); end
    if (router_valid_out !== 1'b0) begin errors++; $display("FAIL lb_router got %b exp 0", router_valid_out); end
`else
    if (router_valid_out !== 1'b1) begin errors++; $display("FAIL self_valid got %b exp 1", router_valid_out); end
    if (router_data_out !== with_top(GID + OFF, sent)) begin errors++; $display("FAIL self_data got %h exp %h", router_data_out, with_top(GID + OFF, sent)); end
    if (gpu_valid_out !== 1'b0) begin errors++; $display("FAIL self_gpu got %b exp 0", gpu_valid_out); end
`endif
    router_ready_in = 1'b1;
    gpu_ready_in = 1'b1;
    cycle();
  endtask

  initial begin
    test_reset();
    test_egress_basic();
    test_ingress_filter();
    test_fill();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_drops();
    test_self_addressed();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
